pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer.sv | 126 ++++++++++++
 tb/tb_pc_sequencer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer
//   Program-counter sequencer with a small instruction memory. While running,
//   the PC advances every non-stalled cycle to pc+1, to a branch target
//   (pc+1 plus a signed offset) or to a jump target (upper bits of pc+1 with
//   new low bits). Jump takes priority over branch. The memory can only be
//   programmed while the sequencer is idle.
//
// Ports
//   clk          : clock, all state updates on the rising edge
//   reset        : synchronous active-high reset
//   run          : 1 = fetch/advance enabled, 0 = return to IDLE
//   stall        : hold PC this cycle
//   branch_taken : apply branch_off this cycle
//   branch_off   : signed offset relative to pc+1
//   jump         : apply jump_target this cycle
//   jump_target  : replacement low PC bits for a jump
//   prog_we      : instruction-memory write strobe (IDLE only)
//   prog_addr    : instruction-memory write address
//   prog_data    : instruction-memory write data
//   pc           : address of the instruction on instr
//   next_pc      : value PC takes at the next advancing edge
//   instr        : mem[pc], combinational read
//   instr_valid  : instr is being executed this cycle
//   halted       : sequencer is IDLE
//   wrapped      : one-cycle pulse after a sequential advance from all-ones to 0
//   retired      : saturating count of executed instructions
module pc_sequencer #(
  parameter int ADDR_W = 8,
  parameter int INSTR_W = 8,
  parameter int BR_W = 3,
  parameter int JMP_W = 5,
  parameter int CNT_W = 16,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [BR_W-1:0]    branch_off,
  input  logic               jump,
  input  logic [JMP_W-1:0]   jump_target,
  input  logic               prog_we,
  input  logic [ADDR_W-1:0]  prog_addr,
  input  logic [INSTR_W-1:0] prog_data,
  output logic [ADDR_W-1:0]  pc,
  output logic [ADDR_W-1:0]  next_pc,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  output logic               halted,
  output logic               wrapped,
  output logic [CNT_W-1:0]   retired
);

  typedef enum logic {IDLE, RUN} state_t;

  // Bits of the PC that a jump replaces; shifting by ADDR_W yields an all-ones mask.
  localparam logic [ADDR_W-1:0] JMP_MASK = ~({ADDR_W{1'b1}} << JMP_W);

  state_t state, state_next;

  logic [INSTR_W-1:0] mem [0:(2**ADDR_W)-1];

  logic [ADDR_W-1:0] pc_plus1;
  logic [ADDR_W-1:0] br_ext;
  logic [ADDR_W-1:0] jump_pc;
  logic              advance;
  logic              seq_wrap;

  assign advance     = (state == RUN) && !stall;
  assign instr_valid = advance;
  assign halted      = (state == IDLE);
  assign instr       = mem[pc];

  // All address arithmetic is modulo 2**ADDR_W by virtue of the ADDR_W-wide results.
  assign pc_plus1 = pc + ADDR_W'(1);
  assign br_ext   = ADDR_W'($signed(branch_off));
  assign jump_pc  = (pc_plus1 & ~JMP_MASK) | ADDR_W'(jump_target);

  // Only a plain pc+1 step from all-ones counts as a wrap; redirects landing on 0 do not.
  assign seq_wrap = advance && !jump && !branch_taken && (pc == {ADDR_W{1'b1}});

  always_comb begin
    next_pc = pc_plus1;
    if (jump) begin
      next_pc = jump_pc;
    end else if (branch_taken) begin
      next_pc = pc_plus1 + br_ext;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (run)  state_next = RUN;
      RUN:     if (!run) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      pc      <= RESET_VEC;
      wrapped <= 1'b0;
      retired <= '0;
    end else begin
      state   <= state_next;
      wrapped <= seq_wrap;
      if (advance) begin
        pc <= next_pc;
        if (retired != {CNT_W{1'b1}}) begin
          retired <= retired + CNT_W'(1);
        end
      end
    end
  end

  // Memory has no reset so a program survives a reset, including one taken mid-run.
  always_ff @(posedge clk) begin
    if (!reset && prog_we && (state == IDLE)) begin
      mem[prog_addr] <= prog_data;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer
//   Directed bench for pc_sequencer. A default instance plus a CNT_W=2
//   instance share all inputs so counter saturation can be observed alongside
//   the normal sequence.
module tb_pc_sequencer;

  logic       clk;
  logic       reset;
  logic       run;
  logic       stall;
  logic       branch_taken;
  logic [2:0] branch_off;
  logic       jump;
  logic [4:0] jump_target;
  logic       prog_we;
  logic [7:0] prog_addr;
  logic [7:0] prog_data;

  logic [7:0]  pc, next_pc, instr;
  logic        instr_valid, halted, wrapped;
  logic [15:0] retired;

  logic [7:0]  pc2, next_pc2, instr2;
  logic        instr_valid2, halted2, wrapped2;
  logic [1:0]  retired2;

  int tests;
  int failures;
  int exp_retired;

  pc_sequencer dut (
    .clk(clk), .reset(reset), .run(run), .stall(stall),
    .branch_taken(branch_taken), .branch_off(branch_off),
    .jump(jump), .jump_target(jump_target),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .pc(pc), .next_pc(next_pc), .instr(instr), .instr_valid(instr_valid),
    .halted(halted), .wrapped(wrapped), .retired(retired)
  );

  pc_sequencer #(.CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .run(run), .stall(stall),
    .branch_taken(branch_taken), .branch_off(branch_off),
    .jump(jump), .jump_target(jump_target),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .pc(pc2), .next_pc(next_pc2), .instr(instr2), .instr_valid(instr_valid2),
    .halted(halted2), .wrapped(wrapped2), .retired(retired2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive control inputs, then let one rising edge pass and settle 1 time unit after it.
  task automatic applyStimulus(input logic r, input logic s, input logic j, input logic b,
                               input logic [4:0] jt, input logic [2:0] bo,
                               input logic pw, input logic adv);
    run          = r;
    stall        = s;
    jump         = j;
    branch_taken = b;
    jump_target  = jt;
    branch_off   = bo;
    prog_we      = pw;
    @(posedge clk);
    #1;
    if (adv) exp_retired++;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  initial begin
    tests = 0;
    failures = 0;
    exp_retired = 0;
    reset = 1'b1;
    prog_addr = 8'h00;
    prog_data = 8'h00;

    // Reset wins over run/jump/branch.
    applyStimulus(1, 0, 1, 1, 5'h1F, 3'b011, 0, 0);
    applyStimulus(1, 0, 1, 1, 5'h1F, 3'b011, 0, 0);
    checkOutput("rst_pc", pc, 8'h00);
    checkOutput("rst_halted", halted, 1);
    checkOutput("rst_wrapped", wrapped, 0);
    checkOutput("rst_retired", retired, 0);
    checkOutput("rst_valid", instr_valid, 0);

    // Program mem[0..4] while idle.
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      prog_addr = 8'(i);
      prog_data = 8'(8'h11 + i);
      applyStimulus(0, 0, 0, 0, 5'h00, 3'b000, 1, 0);
    end
    checkOutput("prog_instr0", instr, 8'h11);
    checkOutput("idle_pc", pc, 8'h00);

    // Enter RUN: no fill cycle, first RUN cycle executes mem[0].
    applyStimulus(1, 0, 0, 0, 5'h00, 3'b000, 0, 0);
    checkOutput("run_valid", instr_valid, 1);
    checkOutput("run_halted", halted, 0);
    for (int i = 0; i < 5; i++) begin
      checkOutput("seq_pc", pc, 32'(i));
      checkOutput("seq_instr", instr, 32'(8'h11 + i));
      applyStimulus(1, 0, 0, 0, 5'h00, 3'b000, 0, 1);
    end
    checkOutput("seq_pc5", pc, 8'h05);
    checkOutput("retired5", retired, 5);
    checkOutput("retired_sat", retired2, 3);

    // Jump to 3, then branch -2 and +3.
    jump = 1'b1;
    jump_target = 5'h03;
    branch_taken = 1'b0;
    #1;
    checkOutput("next_pc_jump", next_pc, 8'h03);
    applyStimulus(1, 0, 1, 0, 5'h03, 3'b000, 0, 1);
    checkOutput("jump_pc3", pc, 8'h03);
    applyStimulus(1, 0, 0, 1, 5'h00, 3'b110, 0, 1);
    checkOutput("branch_neg", pc, 8'h02);
    applyStimulus(1, 0, 0, 0, 5'h00, 3'b000, 0, 1);
    checkOutput("back_to_3", pc, 8'h03);
    applyStimulus(1, 0, 0, 1, 5'h00, 3'b011, 0, 1);
    checkOutput("branch_pos", pc, 8'h07);

    // Reach 0x25, then jump and branch together: jump wins.
    applyStimulus(1, 0, 1, 0, 5'h1F, 3'b000, 0, 1);
    checkOutput("jump_1f", pc, 8'h1F);
    applyStimulus(1, 0, 0, 0, 5'h00, 3'b000, 0, 1);
    checkOutput("seq_20", pc, 8'h20);
    applyStimulus(1, 0, 1, 0, 5'h05, 3'b000, 0, 1);
    checkOutput("jump_25", pc, 8'h25);
    applyStimulus(1, 0, 1, 1, 5'h1F, 3'b011, 0, 1);
    checkOutput("jump_wins", pc, 8'h3F);

    // Chain jumps with target 1F up to 0xFF; none of these is a wrap.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1, 0, 1, 0, 5'h1F, 3'b000, 0, 1);
    end
    checkOutput("chain_ff", pc, 8'hFF);
    checkOutput("chain_nowrap", wrapped, 0);
    applyStimulus(1, 0, 0, 0, 5'h00, 3'b000, 0, 1);
    checkOutput("wrap_pc", pc, 8'h00);
    checkOutput("wrap_pulse", wrapped, 1);
    applyStimulus(1, 0, 0, 0, 5'h00, 3'b000, 0, 1);
    checkOutput("wrap_pc1", pc, 8'h01);
    checkOutput("wrap_cleared", wrapped, 0);

    // Branches landing on 0 (including from 0xFF) must not pulse wrapped.
    applyStimulus(1, 0, 0, 1, 5'h00, 3'b110, 0, 1);
    checkOutput("br_to0_pc", pc, 8'h00);
    checkOutput("br_to0_nowrap", wrapped, 0);
    applyStimulus(1, 0, 0, 1, 5'h00, 3'b110, 0, 1);
    checkOutput("br_to_ff", pc, 8'hFF);
    applyStimulus(1, 0, 0, 1, 5'h00, 3'b000, 0, 1);
    checkOutput("br_ff_to0", pc, 8'h00);
    checkOutput("br_ff_nowrap", wrapped, 0);

    // Stall at pc=6 with jump asserted; attempted write in RUN.
    applyStimulus(1, 0, 1, 0, 5'h06, 3'b000, 0, 1);
    checkOutput("jump_6", pc, 8'h06);
    prog_addr = 8'h00;
    prog_data = 8'hAA;
    stall = 1'b1;
    #1;
    checkOutput("stall_valid", instr_valid, 0);
    applyStimulus(1, 1, 1, 0, 5'h10, 3'b000, 1, 0);
    applyStimulus(1, 1, 1, 0, 5'h10, 3'b000, 1, 0);
    checkOutput("stall_pc", pc, 8'h06);
    checkOutput("stall_retired", retired, 32'(exp_retired));
    checkOutput("stall_retired_sat", retired2, 3);

    // Advance to 9, then run=0 with stall: go IDLE without moving.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 0, 0, 0, 5'h00, 3'b000, 0, 1);
    end
    checkOutput("pc9", pc, 8'h09);
    applyStimulus(0, 1, 0, 0, 5'h00, 3'b000, 0, 0);
    checkOutput("stop_halted", halted, 1);
    checkOutput("stop_pc", pc, 8'h09);
    applyStimulus(0, 0, 1, 1, 5'h01, 3'b011, 0, 0);
    checkOutput("idle_jump_ignored", pc, 8'h09);
    checkOutput("idle_retired", retired, 32'(exp_retired));

    // Resume at pc=9, then reset mid-RUN.
    applyStimulus(1, 0, 0, 0, 5'h00, 3'b000, 0, 0);
    checkOutput("resume_valid", instr_valid, 1);
    checkOutput("resume_pc", pc, 8'h09);
    reset = 1'b1;
    applyStimulus(1, 0, 1, 0, 5'h1F, 3'b000, 1, 0);
    checkOutput("midrst_pc", pc, 8'h00);
    checkOutput("midrst_halted", halted, 1);
    checkOutput("midrst_retired", retired, 0);
    checkOutput("midrst_retired_sat", retired2, 0);
    checkOutput("midrst_valid", instr_valid, 0);
    reset = 1'b0;
    applyStimulus(0, 0, 0, 0, 5'h00, 3'b000, 0, 0);
    checkOutput("mem_retained", instr, 8'h11);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
